// File: rtl/tpmem_ctrl.sv
// -----------------------------------------------------------------------------
// tpmem_ctrl
// Sequencer for an 8x8 transpose memory (TP mem).
//   - Takes a row stream over a valid/ready handshake.
//   - Forwards each accepted row to the memory as a write, but only while the
//     memory is in its row-load phase.
//   - Mirrors the memory's 4-bit phase counter so that each column leaving the
//     memory can be tagged with its index, a last-column flag and frame
//     accounting.
//   - Drives the memory's synchronous active-low reset, which is also how a
//     flush is performed.
//
// Ports
//   i_clk         clock, rising edge
//   i_Reset       asynchronous active-low reset
//   i_flush       synchronous abort of the partial or draining block
//   s_valid       upstream row valid
//   s_data        upstream row, 8 elements of BW bits, element 0 in the MSBs
//   s_ready       a row can be accepted this cycle
//   o_tp_en       TP mem write enable (i_enable)
//   o_tp_data     TP mem write data (i_data), combinational copy of s_data
//   o_tp_rstn     TP mem synchronous active-low reset
//   o_col_valid   TP mem output column valid this cycle
//   o_col_idx     index of the column currently on the TP mem output
//   o_col_last    high together with column 7
//   o_blk_cnt     completed blocks, wraps at 2^BCW
//   o_frame_done  one-cycle pulse with the last column of the last block of a frame
// -----------------------------------------------------------------------------
module tpmem_ctrl #(
   parameter int BW        = 10,
   parameter int BLK_FRAME = 16,
   parameter int BCW       = 16
) (
   input  logic            i_clk,
   input  logic            i_Reset,
   input  logic            i_flush,
   input  logic            s_valid,
   input  logic [8*BW-1:0] s_data,
   output logic            s_ready,
   output logic            o_tp_en,
   output logic [8*BW-1:0] o_tp_data,
   output logic            o_tp_rstn,
   output logic            o_col_valid,
   output logic [2:0]      o_col_idx,
   output logic            o_col_last,
   output logic [BCW-1:0]  o_blk_cnt,
   output logic            o_frame_done
);

   // Width of the block-in-frame counter; one bit minimum so BLK_FRAME=1 works.
   localparam int FW = (BLK_FRAME > 1) ? $clog2(BLK_FRAME) : 1;
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLK_FRAME - 1);

   // Phase counter: cnt[3]=0 is the row-load phase, cnt[3]=1 the column drain.
   logic [3:0]     cnt_q,          cnt_d;
   logic [FW-1:0]  blk_in_frame_q, blk_in_frame_d;
   logic [BCW-1:0] blk_cnt_q,      blk_cnt_d;
   logic           tp_rstn_q,      tp_rstn_d;
   logic           col_valid_q,    col_valid_d;
   logic [2:0]     col_idx_q,      col_idx_d;
   logic           col_last_q,     col_last_d;
   logic           frame_done_q,   frame_done_d;

   logic drain;
   logic ready;
   logic wr_en;

   always_comb begin
      drain = cnt_q[3];
      // While the memory is held in reset or a flush is pending, no row may be
      // written, otherwise it would be lost by the memory.
      ready = ~drain & tp_rstn_q & ~i_flush;
      wr_en = s_valid & ready;

      cnt_d          = cnt_q;
      blk_in_frame_d = blk_in_frame_q;
      blk_cnt_d      = blk_cnt_q;
      tp_rstn_d      = tp_rstn_q;
      col_valid_d    = col_valid_q;
      col_idx_d      = col_idx_q;
      col_last_d     = col_last_q;
      frame_done_d   = frame_done_q;

      if (i_flush) begin
         // Flush wins over everything: restart the memory and the mirror
         // counter, silence the column tags, keep the block accounting.
         cnt_d        = 4'd0;
         tp_rstn_d    = 1'b0;
         col_valid_d  = 1'b0;
         col_idx_d    = 3'd0;
         col_last_d   = 1'b0;
         frame_done_d = 1'b0;
      end else begin
         tp_rstn_d = 1'b1;

         // Tags lag the counter by one cycle, like the memory's registered output.
         col_valid_d  = drain;
         col_idx_d    = drain ? cnt_q[2:0] : 3'd0;
         col_last_d   = (cnt_q == 4'd15);
         frame_done_d = 1'b0;

         // Load advances only on a write; drain runs free and wraps 15 -> 0.
         if (drain || wr_en) begin
            cnt_d = cnt_q + 4'd1;
         end

         if (cnt_q == 4'd15) begin
            blk_cnt_d = blk_cnt_q + BCW'(1);
            if (blk_in_frame_q == FRAME_LAST) begin
               blk_in_frame_d = '0;
               frame_done_d   = 1'b1;
            end else begin
               blk_in_frame_d = blk_in_frame_q + FW'(1);
            end
         end
      end
   end

   // o_tp_rstn is a register cleared by the async reset, so the memory sees
   // its reset low on every clock edge while i_Reset is asserted.
   always_ff @(posedge i_clk or negedge i_Reset) begin
      if (!i_Reset) begin
         cnt_q          <= 4'd0;
         blk_in_frame_q <= '0;
         blk_cnt_q      <= '0;
         tp_rstn_q      <= 1'b0;
         col_valid_q    <= 1'b0;
         col_idx_q      <= 3'd0;
         col_last_q     <= 1'b0;
         frame_done_q   <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         blk_in_frame_q <= blk_in_frame_d;
         blk_cnt_q      <= blk_cnt_d;
         tp_rstn_q      <= tp_rstn_d;
         col_valid_q    <= col_valid_d;
         col_idx_q      <= col_idx_d;
         col_last_q     <= col_last_d;
         frame_done_q   <= frame_done_d;
      end
   end

   assign s_ready      = ready;
   assign o_tp_en      = wr_en;
   assign o_tp_data    = s_data;
   assign o_tp_rstn    = tp_rstn_q;
   assign o_col_valid  = col_valid_q;
   assign o_col_idx    = col_idx_q;
   assign o_col_last   = col_last_q;
   assign o_blk_cnt    = blk_cnt_q;
   assign o_frame_done = frame_done_q;

endmodule
